// File: rtl/rails_scheduler.sv
// Two-port round-robin front end for a shared rails checker: buffers the granted port's
// permutation, replays it to the checker as one burst and returns the result to the owner.
module rails_scheduler #(
  parameter int unsigned MAX_LEN = 10,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [3:0] num0,
  input  logic [3:0] num1,
  output logic [1:0] gnt,
  input  logic       in_valid,
  input  logic [3:0] in_data1,
  input  logic [3:0] in_data2,
  output logic       in_ready,
  output logic       chk_start,
  output logic [3:0] chk_number,
  output logic       chk_dvalid,
  output logic [3:0] chk_data1,
  output logic [3:0] chk_data2,
  input  logic       chk_valid,
  input  logic       chk_result1,
  input  logic       chk_result2,
  output logic       done,
  output logic       done_id,
  output logic       result1,
  output logic       result2,
  output logic       err
);

  localparam logic [3:0] MaxLen  = 4'(MAX_LEN);
  localparam logic [7:0] Timeout = 8'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StLoad, StIssue, StStream, StWait, StReport} state_e;

  state_e     state_q, state_d;
  logic [3:0] len_q, len_d;
  logic [3:0] count_q, count_d;
  logic [7:0] timer_q, timer_d;
  logic       last_id_q, last_id_d;
  logic       port_q, port_d;
  logic [3:0] buf1_q [MAX_LEN];
  logic [3:0] buf1_d [MAX_LEN];
  logic [3:0] buf2_q [MAX_LEN];
  logic [3:0] buf2_d [MAX_LEN];

  logic [1:0] gnt_q, gnt_d;
  logic       in_ready_q, in_ready_d;
  logic       chk_start_q, chk_start_d;
  logic [3:0] chk_number_q, chk_number_d;
  logic       chk_dvalid_q, chk_dvalid_d;
  logic [3:0] chk_data1_q, chk_data1_d;
  logic [3:0] chk_data2_q, chk_data2_d;
  logic       done_q, done_d;
  logic       done_id_q, done_id_d;
  logic       result1_q, result1_d;
  logic       result2_q, result2_d;
  logic       err_q, err_d;
  logic       pick;
  logic [3:0] pick_len;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    count_d      = count_q;
    timer_d      = timer_q;
    last_id_d    = last_id_q;
    port_d       = port_q;
    buf1_d       = buf1_q;
    buf2_d       = buf2_q;
    gnt_d        = gnt_q;
    in_ready_d   = 1'b0;
    chk_start_d  = 1'b0;
    chk_number_d = 4'd0;
    chk_dvalid_d = 1'b0;
    chk_data1_d  = 4'd0;
    chk_data2_d  = 4'd0;
    done_d       = 1'b0;
    done_id_d    = 1'b0;
    result1_d    = 1'b0;
    result2_d    = 1'b0;
    err_d        = 1'b0;
    // When both request, the port that was not served last wins
    pick         = (req == 2'b11) ? ~last_id_q : req[1];
    pick_len     = pick ? num1 : num0;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          port_d    = pick;
          last_id_d = pick;
          len_d     = pick_len;
          gnt_d     = pick ? 2'b10 : 2'b01;
          count_d   = 4'd0;
          timer_d   = 8'd0;
          if (pick_len == 4'd0 || pick_len > MaxLen) begin
            state_d   = StReport;
            done_d    = 1'b1;
            done_id_d = pick;
            err_d     = 1'b1;
          end else begin
            state_d    = StLoad;
            in_ready_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (in_valid && in_ready_q) begin
          buf1_d[count_q] = in_data1;
          buf2_d[count_q] = in_data2;
          count_d         = count_q + 4'd1;
        end
        if (count_d == len_q) begin
          state_d      = StIssue;
          chk_start_d  = 1'b1;
          chk_number_d = len_q;
          count_d      = 4'd0;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      StIssue: begin
        state_d      = StStream;
        chk_dvalid_d = 1'b1;
        chk_data1_d  = buf1_q[0];
        chk_data2_d  = buf2_q[0];
        count_d      = 4'd1;
      end
      StStream: begin
        if (count_q == len_q) begin
          state_d = StWait;
          timer_d = 8'd0;
        end else begin
          chk_dvalid_d = 1'b1;
          chk_data1_d  = buf1_q[count_q];
          chk_data2_d  = buf2_q[count_q];
          count_d      = count_q + 4'd1;
        end
      end
      StWait: begin
        if (chk_valid) begin
          state_d   = StReport;
          done_d    = 1'b1;
          done_id_d = port_q;
          result1_d = chk_result1;
          result2_d = chk_result2;
        end else if (timer_q == Timeout) begin
          state_d   = StReport;
          done_d    = 1'b1;
          done_id_d = port_q;
          err_d     = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StReport: begin
        state_d = StIdle;
        gnt_d   = 2'b00;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      len_q        <= 4'd0;
      count_q      <= 4'd0;
      timer_q      <= 8'd0;
      last_id_q    <= 1'b1;
      port_q       <= 1'b0;
      buf1_q       <= '{default: 4'd0};
      buf2_q       <= '{default: 4'd0};
      gnt_q        <= 2'b00;
      in_ready_q   <= 1'b0;
      chk_start_q  <= 1'b0;
      chk_number_q <= 4'd0;
      chk_dvalid_q <= 1'b0;
      chk_data1_q  <= 4'd0;
      chk_data2_q  <= 4'd0;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
      result1_q    <= 1'b0;
      result2_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      last_id_q    <= last_id_d;
      port_q       <= port_d;
      buf1_q       <= buf1_d;
      buf2_q       <= buf2_d;
      gnt_q        <= gnt_d;
      in_ready_q   <= in_ready_d;
      chk_start_q  <= chk_start_d;
      chk_number_q <= chk_number_d;
      chk_dvalid_q <= chk_dvalid_d;
      chk_data1_q  <= chk_data1_d;
      chk_data2_q  <= chk_data2_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
      result1_q    <= result1_d;
      result2_q    <= result2_d;
      err_q        <= err_d;
    end
  end

  assign gnt        = gnt_q;
  assign in_ready   = in_ready_q;
  assign chk_start  = chk_start_q;
  assign chk_number = chk_number_q;
  assign chk_dvalid = chk_dvalid_q;
  assign chk_data1  = chk_data1_q;
  assign chk_data2  = chk_data2_q;
  assign done       = done_q;
  assign done_id    = done_id_q;
  assign result1    = result1_q;
  assign result2    = result2_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rails_scheduler.sv
// Randomized bench for rails_scheduler: acts as both requesters and as the checker, and
// predicts grant order, burst contents, results and error cases from a transaction model.
module tb_rails_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [3:0] num0, num1;
  logic [1:0] gnt;
  logic       in_valid;
  logic [3:0] in_data1, in_data2;
  logic       in_ready;
  logic       chk_start;
  logic [3:0] chk_number;
  logic       chk_dvalid;
  logic [3:0] chk_data1, chk_data2;
  logic       chk_valid, chk_result1, chk_result2;
  logic       done, done_id, result1, result2, err;

  int n_vec = 0;
  int n_err = 0;
  int starts_seen = 0;
  bit last_id_m = 1'b1;

  rails_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .num0       (num0),
    .num1       (num1),
    .gnt        (gnt),
    .in_valid   (in_valid),
    .in_data1   (in_data1),
    .in_data2   (in_data2),
    .in_ready   (in_ready),
    .chk_start  (chk_start),
    .chk_number (chk_number),
    .chk_dvalid (chk_dvalid),
    .chk_data1  (chk_data1),
    .chk_data2  (chk_data2),
    .chk_valid  (chk_valid),
    .chk_result1(chk_result1),
    .chk_result2(chk_result2),
    .done       (done),
    .done_id    (done_id),
    .result1    (result1),
    .result2    (result2),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (chk_start) starts_seen++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {10'd0, gnt, in_ready, chk_start, chk_number, chk_dvalid, chk_data1, chk_data2,
            done, done_id, result1, result2, err};
  endfunction

  // Round robin: a lone requester wins, a tie goes to the port not served last
  function automatic bit pick_port(input logic [1:0] r);
    if (r == 2'b11) return !last_id_m;
    return r[1];
  endfunction

  task automatic run_case(input logic [1:0] rq, input logic [3:0] n0, input logic [3:0] n1,
                          input bit toggle, input bit silent, input bit abort, input bit dir);
    logic [3:0] q1[$];
    logic [3:0] q2[$];
    bit   p;
    int   len, idx, budget, k, s0;
    bit   rdy;
    logic r1, r2;
    p   = pick_port(rq);
    len = p ? int'(n1) : int'(n0);
    req = rq; num0 = n0; num1 = n1;
    step();
    check_eq("gnt_rise", gnt, p ? 2'b10 : 2'b01);
    last_id_m = p;
    // Drop request and scramble lengths: the case must run from the latched values
    req = 2'b00; num0 = 4'($urandom); num1 = 4'($urandom);
    if (len == 0 || len > 10) begin
      s0 = starts_seen;
      k  = 0;
      while (!done && k < 2) begin step(); k++; end
      check_eq("badlen_done", done, 1);
      check_eq("badlen_id", done_id, p);
      check_eq("badlen_err", err, 1);
      check_eq("badlen_res", {result1, result2}, 0);
      step();
      check_eq("badlen_gnt_clr", gnt, 0);
      check_eq("badlen_no_start", starts_seen, s0);
      return;
    end
    for (int i = 0; i < len; i++) begin
      q1.push_back(dir ? 4'(i + 1) : 4'($urandom));
      q2.push_back(dir ? 4'(len - i) : 4'($urandom));
    end
    idx = 0; budget = 0;
    while (idx < len && budget < 200) begin
      rdy       = in_ready;
      in_valid  = toggle ? (budget % 2 == 0) : 1'($urandom_range(0, 1));
      in_data1  = q1[idx];
      in_data2  = q2[idx];
      chk_valid = 1'($urandom_range(0, 1));
      chk_result1 = 1'b1; chk_result2 = 1'b1;
      step();
      if (in_valid && rdy) idx++;
      budget++;
    end
    in_valid = 1'b0; chk_valid = 1'b0;
    check_eq("load_budget", idx, len);
    k = 0;
    while (!chk_start && k < 5) begin step(); k++; end
    check_eq("chk_start", chk_start, 1);
    check_eq("chk_number", chk_number, len);
    check_eq("ready_after_load", in_ready, 0);
    step();
    for (int i = 0; i < len; i++) begin
      check_eq("dvalid", chk_dvalid, 1);
      check_eq("beat", {chk_data1, chk_data2}, {q1[i], q2[i]});
      if (abort && i == 1) begin
        #2 reset = 1'b1;
        #1 check_eq("abort_outs_zero", all_outs(), 0);
        reset = 1'b0;
        last_id_m = 1'b1;
        return;
      end
      step();
    end
    check_eq("dvalid_end", chk_dvalid, 0);
    if (silent) begin
      repeat (255) step();
      check_eq("timeout_early", done, 0);
      step();
      check_eq("timeout_done", done, 1);
      check_eq("timeout_err", err, 1);
      check_eq("timeout_res", {result1, result2}, 0);
      check_eq("timeout_id", done_id, p);
    end else begin
      repeat ($urandom_range(0, 6)) step();
      check_eq("done_early", done, 0);
      r1 = dir ? 1'b1 : 1'($urandom);
      r2 = dir ? 1'b0 : 1'($urandom);
      chk_valid = 1'b1; chk_result1 = r1; chk_result2 = r2;
      step();
      chk_valid = 1'b0; chk_result1 = 1'b0; chk_result2 = 1'b0;
      check_eq("done", done, 1);
      check_eq("done_id", done_id, p);
      check_eq("results", {result1, result2}, {r1, r2});
      check_eq("err_ok", err, 0);
      check_eq("gnt_held", gnt, p ? 2'b10 : 2'b01);
    end
    step();
    check_eq("done_pulse", done, 0);
    check_eq("gnt_clr", gnt, 0);
  endtask

  initial begin
    logic [1:0] rq;
    logic [3:0] a, b;
    reset = 1'b1; req = 0; num0 = 0; num1 = 0; in_valid = 0; in_data1 = 0; in_data2 = 0;
    chk_valid = 0; chk_result1 = 0; chk_result2 = 0;
    #12;
    check_eq("reset_outs", all_outs(), 0);
    reset = 1'b0;
    step();

    run_case(2'b01, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1; #3 reset = 1'b0; last_id_m = 1'b1;
    step();
    run_case(2'b11, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    run_case(2'b11, 4'd2, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    run_case(2'b11, 4'd10, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_case(2'b01, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    run_case(2'b01, 4'd11, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    run_case(2'b10, 4'd2, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    run_case(2'b10, 4'd7, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    run_case(2'b01, 4'd3, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    run_case(2'b11, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      rq = 2'($urandom_range(1, 3));
      a  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(1, 10));
      b  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(1, 10));
      run_case(rq, a, b, 1'($urandom), (t == 12), 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) step();
    end

    run_case(2'b11, 4'd7, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    run_case(2'b11, 4'd6, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
